// File: rtl/kalman_gain_scaler.sv
// Scales a frame of N_ELEM cross-covariance entries by a latched reciprocal 1/S
// to produce saturated Q8.24 Kalman gains over valid/ready streams.
module kalman_gain_scaler #(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 24,
  parameter int N_ELEM    = 4,
  parameter int IDX_W     = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              inv_done,
  input  logic [DATA_W-1:0] inv_q,
  input  logic              pxz_valid,
  output logic              pxz_ready,
  input  logic [DATA_W-1:0] pxz_data,
  output logic              k_valid,
  input  logic              k_ready,
  output logic [DATA_W-1:0] k_data,
  output logic [IDX_W-1:0]  k_idx,
  output logic              k_last,
  output logic              busy,
  output logic              frame_done,
  output logic              sat_flag,
  output logic              ovr_flag
);

  localparam int PW = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              last;
  } kout_t;

  state_t            state_q, state_d;
  kout_t             kout_q, kout_d;
  logic              inv_done_q;
  logic [DATA_W-1:0] q_q, q_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              fd_q, fd_d;
  logic              sat_q, sat_d;
  logic              ovr_q, ovr_d;

  logic              start, accept, out_hs, last_idx;
  logic signed [PW-1:0] full, sh;
  logic              ovf;
  logic [DATA_W-1:0] prod_sat;

  assign start    = inv_done & ~inv_done_q;
  assign last_idx = (idx_q == IDX_W'(N_ELEM - 1));
  assign out_hs   = kout_q.vld & k_ready;

  assign pxz_ready = (state_q == RUN) & (~kout_q.vld | k_ready);
  assign accept    = pxz_valid & pxz_ready;

  // Floor shift back to Q8.24; anything not representable in DATA_W clamps.
  assign full     = PW'($signed(pxz_data)) * PW'($signed(q_q));
  assign sh       = full >>> FRAC_BITS;
  assign ovf      = (sh[PW-1:DATA_W-1] != {(DATA_W+1){sh[PW-1]}});
  assign prod_sat = ovf ? (sh[PW-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                    : {1'b0, {(DATA_W-1){1'b1}}})
                        : sh[DATA_W-1:0];

  always_comb begin
    state_d = state_q;
    kout_d  = kout_q;
    q_d     = q_q;
    idx_d   = idx_q;
    fd_d    = 1'b0;
    sat_d   = sat_q;
    ovr_d   = ovr_q;

    if (out_hs) kout_d.vld = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          q_d     = inv_q;
          idx_d   = '0;
          sat_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // A new accept overrides the clear from a same-cycle output handshake.
        if (accept) begin
          kout_d.vld  = 1'b1;
          kout_d.data = prod_sat;
          kout_d.idx  = idx_q;
          kout_d.last = last_idx;
          idx_d       = idx_q + IDX_W'(1);
          if (ovf) sat_d = 1'b1;
          if (last_idx) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_hs && kout_q.last) begin
          fd_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start && state_q != IDLE) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      kout_q     <= '0;
      inv_done_q <= 1'b0;
      q_q        <= '0;
      idx_q      <= '0;
      fd_q       <= 1'b0;
      sat_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      kout_q     <= kout_d;
      inv_done_q <= inv_done;
      q_q        <= q_d;
      idx_q      <= idx_d;
      fd_q       <= fd_d;
      sat_q      <= sat_d;
      ovr_q      <= ovr_d;
    end
  end

  assign k_valid    = kout_q.vld;
  assign k_data     = kout_q.data;
  assign k_idx      = kout_q.idx;
  assign k_last     = kout_q.last;
  assign busy       = (state_q != IDLE);
  assign frame_done = fd_q;
  assign sat_flag   = sat_q;
  assign ovr_flag   = ovr_q;

endmodule

// File: tb/tb_kalman_gain_scaler.sv
// Self-checking bench for kalman_gain_scaler: directed frames plus randomized
// frames against an arithmetic reference model of the gain scaling.
module tb_kalman_gain_scaler;
  localparam int N = 4;

  logic        clk = 0, rstn = 0;
  logic        inv_done = 0, pxz_valid = 0, k_ready = 0;
  logic [31:0] inv_q = 0, pxz_data = 0;
  logic        pxz_ready, k_valid, k_last, busy, frame_done, sat_flag, ovr_flag;
  logic [31:0] k_data;
  logic [1:0]  k_idx;

  int checks = 0, errors = 0;
  bit exp_ovr = 0;

  kalman_gain_scaler #(.DATA_W(32), .FRAC_BITS(24), .N_ELEM(N), .IDX_W(2)) dut (
    .clk(clk), .rstn(rstn), .inv_done(inv_done), .inv_q(inv_q),
    .pxz_valid(pxz_valid), .pxz_ready(pxz_ready), .pxz_data(pxz_data),
    .k_valid(k_valid), .k_ready(k_ready), .k_data(k_data), .k_idx(k_idx),
    .k_last(k_last), .busy(busy), .frame_done(frame_done),
    .sat_flag(sat_flag), .ovr_flag(ovr_flag));

  always #5 clk = ~clk;

  // {clamped, gain}: real-number product divided by 2^24 with floor, then clamped.
  function automatic logic [32:0] ref_gain(input logic [31:0] p, input logic [31:0] q);
    longint prod, fl;
    prod = longint'($signed(p)) * longint'($signed(q));
    fl = prod / 64'sd16777216;
    if (prod < 0 && (prod % 64'sd16777216) != 0) fl = fl - 1;
    if (fl > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
    if (fl < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, fl[31:0]};
  endfunction

  // rmode: 0 always ready, 1 random ready, 2 five-cycle stall after first gain.
  // hold: cycles inv_done stays high; rr: cycle of a second rise (0 = none).
  task automatic run_frame(input logic [31:0] q, input logic [31:0] p0, p1, p2, p3,
                           input int rmode, input int vgap, input int hold, input int rr);
    logic [31:0] p[N];
    logic [32:0] r;
    logic [31:0] prev_data;
    logic [1:0]  prev_idx;
    bit prev_stall = 0, exp_sat = 0;
    int sent = 0, got = 0, c = 0, stall = 0, done_c = -1;
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    if (rr > 0) exp_ovr = 1;
    while (1) begin
      @(negedge clk);
      inv_done  = (c < hold) || (rr > 0 && c == rr);
      inv_q     = (c == 0) ? q : $urandom;
      pxz_valid = (sent < N) && (vgap == 0 || $urandom_range(0, vgap) == 0);
      pxz_data  = pxz_valid ? p[sent] : $urandom;
      case (rmode)
        0: k_ready = 1;
        1: k_ready = $urandom_range(0, 1);
        default: begin
          if (got >= 1 && stall < 5) begin k_ready = 0; stall++; end
          else k_ready = 1;
        end
      endcase
      #1;
      if (prev_stall) begin
        checks++;
        if (k_valid !== 1'b1 || k_data !== prev_data || k_idx !== prev_idx) begin
          errors++;
          $display("FAIL hold_stable: got v=%b d=%h i=%0d required v=1 d=%h i=%0d",
                   k_valid, k_data, k_idx, prev_data, prev_idx);
        end
      end
      if (k_valid && !k_ready) begin
        checks++;
        if (pxz_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_backpressure: got pxz_ready=%b required 0", pxz_ready);
        end
      end
      prev_stall = k_valid && !k_ready;
      prev_data  = k_data;
      prev_idx   = k_idx;
      if (c == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_start: got %b required 1", busy);
        end
      end
      if (k_valid && k_ready) begin
        checks++;
        if (got >= N) begin
          errors++;
          $display("FAIL extra_gain: got idx=%0d data=%h required none", k_idx, k_data);
        end else begin
          r = ref_gain(p[got], q);
          exp_sat |= r[32];
          if (k_data !== r[31:0] || k_idx !== 2'(got) || k_last !== (got == N - 1)) begin
            errors++;
            $display("FAIL gain: got d=%h i=%0d l=%b required d=%h i=%0d l=%b",
                     k_data, k_idx, k_last, r[31:0], got, (got == N - 1));
          end
          got++;
          if (got == N) done_c = c + 1;
        end
      end
      checks++;
      if (c == done_c) begin
        if (frame_done !== 1'b1 || k_valid !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL frame_done: got fd=%b kv=%b busy=%b required 1 0 0",
                   frame_done, k_valid, busy);
        end
      end else if (frame_done !== 1'b0) begin
        errors++;
        $display("FAIL frame_done_spurious: got 1 required 0 at cycle %0d", c);
      end
      if (pxz_valid && pxz_ready) sent++;
      if (done_c >= 0 && c >= done_c && c >= hold) break;
      c++;
      if (c > 300) begin
        errors++;
        $display("FAIL frame_timeout: got %0d gains required %0d", got, N);
        break;
      end
    end
    @(negedge clk);
    inv_done = 0; pxz_valid = 0;
    #1;
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || sat_flag !== exp_sat || ovr_flag !== exp_ovr) begin
      errors++;
      $display("FAIL frame_end: got fd=%b busy=%b sat=%b ovr=%b required 0 0 %b %b",
               frame_done, busy, sat_flag, ovr_flag, exp_sat, exp_ovr);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({pxz_ready, k_valid, k_data, k_idx, k_last, busy, frame_done, sat_flag, ovr_flag} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got kv=%b kd=%h busy=%b required all zero", k_valid, k_data, busy);
    end
    repeat (2) @(negedge clk);
    rstn = 1;
  endtask

  task automatic test_basic();
    run_frame(32'h0080_0000, 32'h0100_0000, 32'h0200_0000, 32'hFD00_0000, 32'h0040_0000, 0, 0, 1, 0);
    checks++;
    if (k_data !== 32'h0020_0000) begin
      errors++;
      $display("FAIL basic_last_gain: got %h required 00200000", k_data);
    end
  endtask

  task automatic test_saturation();
    run_frame(32'h4000_0000, 32'h1000_0000, 32'hF000_0000, 32'h0000_0100, 32'hFFFF_FF00, 0, 0, 1, 0);
  endtask

  task automatic test_truncation();
    run_frame(32'h0080_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0003, 0, 0, 1, 0);
  endtask

  task automatic test_backpressure();
    run_frame(32'h0123_4567, 32'h0200_0000, 32'hFF00_0000, 32'h0080_0000, 32'h7000_0000, 2, 0, 1, 0);
  endtask

  task automatic test_level_hold();
    run_frame(32'h0100_0000, 32'h0111_1111, 32'h0222_2222, 32'h0333_3333, 32'h0444_4444, 0, 0, 20, 0);
  endtask

  task automatic test_overrun();
    run_frame(32'h0200_0000, 32'h0100_0000, 32'h0080_0000, 32'hFF80_0000, 32'h0010_0000, 0, 0, 1, 3);
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      logic [31:0] q;
      q = $urandom_range(0, 32'h03FF_FFFF);
      if ($urandom_range(0, 1)) q = -q;
      if (f == 3) q = 32'h7FFF_FFFF;
      run_frame(q, $urandom, $urandom >> $urandom_range(0, 31), $urandom, $urandom >> 8,
                1, 2, 1, 0);
    end
  endtask

  task automatic test_async_reset();
    int acc = 0, c = 0;
    @(negedge clk);
    inv_done = 1; inv_q = 32'h0300_0000; k_ready = 1;
    while (acc < 2 && c < 50) begin
      @(negedge clk);
      pxz_valid = 1; pxz_data = 32'h0100_0000;
      #1;
      if (pxz_ready) acc++;
      c++;
    end
    @(negedge clk);
    #1;
    rstn = 0; inv_done = 0; pxz_valid = 0;
    exp_ovr = 0;
    #1;
    checks++;
    if ({pxz_ready, k_valid, k_data, k_idx, k_last, busy, frame_done, sat_flag, ovr_flag} !== '0) begin
      errors++;
      $display("FAIL async_reset: got kv=%b kd=%h ki=%0d busy=%b ovr=%b required all zero",
               k_valid, k_data, k_idx, busy, ovr_flag);
    end
    repeat (2) @(negedge clk);
    rstn = 1;
    run_frame(32'h0180_0000, 32'h0100_0000, 32'hFF00_0000, 32'h0020_0000, 32'hFFF0_0000, 0, 0, 1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_truncation();
    test_backpressure();
    test_level_hold();
    test_overrun();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
